// File: rtl/serdesphy_pkg.sv
// Shared types and default timing constants for the SerDes PHY link controller.
package serdesphy_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PWR_WAIT = 3'd1,
    ST_PLL_WAIT = 3'd2,
    ST_CDR_WAIT = 3'd3,
    ST_PRBS_CHK = 3'd4,
    ST_LINK_UP  = 3'd5,
    ST_FAULT    = 3'd6
  } link_state_e;

  localparam int unsigned DEF_PWR_SETTLE  = 256;
  localparam int unsigned DEF_PLL_TIMEOUT = 4096;
  localparam int unsigned DEF_CDR_TIMEOUT = 8192;
  localparam int unsigned DEF_PRBS_WINDOW = 1024;
  localparam int unsigned DEF_MAX_RETRY   = 3;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/serdesphy_sync2.sv
// Two-flop synchronizer for asynchronous lock indications; clears to 0 on reset.
module serdesphy_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serdesphy_link_ctrl.sv
// SerDes PHY link bring-up sequencer: supplies -> PLL -> CDR -> optional PRBS -> link up,
// with per-stage timeouts, bounded retry and in-service lock monitoring.
module serdesphy_link_ctrl
  import serdesphy_pkg::*;
#(
  parameter int unsigned PWR_SETTLE  = DEF_PWR_SETTLE,
  parameter int unsigned PLL_TIMEOUT = DEF_PLL_TIMEOUT,
  parameter int unsigned CDR_TIMEOUT = DEF_CDR_TIMEOUT,
  parameter int unsigned PRBS_WINDOW = DEF_PRBS_WINDOW,
  parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic       clk_ref_24m,
  input  logic       rst_n,
  input  logic       dvdd_ok,
  input  logic       avdd_ok,
  input  logic       link_en,
  input  logic       test_mode,
  input  logic       pll_lock,
  input  logic       cdr_lock,
  input  logic       prbs_err,
  output logic       pll_en,
  output logic       cdr_en,
  output logic       tx_en,
  output logic       rx_en,
  output logic       prbs_chk_en,
  output logic       link_up,
  output logic       fault,
  output logic [2:0] state,
  output logic [1:0] retry_cnt
);

  localparam int unsigned TW = $clog2(max4(PWR_SETTLE, PLL_TIMEOUT, CDR_TIMEOUT, PRBS_WINDOW));
  localparam logic [TW-1:0] PWR_LAST  = TW'(PWR_SETTLE - 1);
  localparam logic [TW-1:0] PLL_LAST  = TW'(PLL_TIMEOUT - 1);
  localparam logic [TW-1:0] CDR_LAST  = TW'(CDR_TIMEOUT - 1);
  localparam logic [TW-1:0] PRBS_LAST = TW'(PRBS_WINDOW - 1);
  localparam logic [1:0]    RETRY_LAST = 2'(MAX_RETRY - 1);

  link_state_e   st, nxt;
  logic [TW-1:0] timer, prbs_tot;
  logic          pll_s, cdr_s, pwr_ok;
  logic          retry_ev, retry_inc, timer_clr, timed;

  serdesphy_sync2 u_pll_sync (.clk(clk_ref_24m), .rst_n(rst_n), .d(pll_lock), .q(pll_s));
  serdesphy_sync2 u_cdr_sync (.clk(clk_ref_24m), .rst_n(rst_n), .d(cdr_lock), .q(cdr_s));

  assign pwr_ok = dvdd_ok & avdd_ok;
  assign state  = st;

  always_comb begin
    nxt      = st;
    retry_ev = 1'b0;
    unique case (st)
      ST_OFF:      if (link_en && pwr_ok) nxt = ST_PWR_WAIT;
      ST_PWR_WAIT: if (pwr_ok && timer == PWR_LAST) nxt = ST_PLL_WAIT;
      // lock is tested ahead of the timeout so a coincident lock wins
      ST_PLL_WAIT: if (pll_s) nxt = ST_CDR_WAIT;
                   else if (timer == PLL_LAST) retry_ev = 1'b1;
      ST_CDR_WAIT: if (cdr_s) nxt = test_mode ? ST_PRBS_CHK : ST_LINK_UP;
                   else if (timer == CDR_LAST) retry_ev = 1'b1;
      ST_PRBS_CHK: if (!prbs_err && timer == PRBS_LAST) nxt = ST_LINK_UP;
                   else if (prbs_tot == CDR_LAST) retry_ev = 1'b1;
      ST_LINK_UP:  if (!pll_s || !cdr_s) retry_ev = 1'b1;
      ST_FAULT:    nxt = ST_FAULT;
      default:     nxt = ST_OFF;
    endcase
    if (retry_ev) nxt = (retry_cnt == RETRY_LAST) ? ST_FAULT : ST_PWR_WAIT;
    // supply loss restarts bring-up without charging a retry; link_en=0 overrides all
    if (!pwr_ok && st != ST_OFF && st != ST_FAULT) nxt = ST_PWR_WAIT;
    if (!link_en) nxt = ST_OFF;
    retry_inc = retry_ev && link_en && pwr_ok && (retry_cnt != RETRY_LAST);
    timer_clr = (nxt != st) || (st == ST_PRBS_CHK && prbs_err) ||
                (st == ST_PWR_WAIT && !pwr_ok);
    timed     = nxt inside {ST_PWR_WAIT, ST_PLL_WAIT, ST_CDR_WAIT, ST_PRBS_CHK};
  end

  always_ff @(posedge clk_ref_24m or negedge rst_n) begin
    if (!rst_n) begin
      st          <= ST_OFF;
      timer       <= '0;
      prbs_tot    <= '0;
      retry_cnt   <= '0;
      pll_en      <= 1'b0;
      cdr_en      <= 1'b0;
      tx_en       <= 1'b0;
      rx_en       <= 1'b0;
      prbs_chk_en <= 1'b0;
      link_up     <= 1'b0;
      fault       <= 1'b0;
    end else begin
      st       <= nxt;
      timer    <= (timer_clr || !timed) ? '0 : timer + 1'b1;
      prbs_tot <= (st == ST_PRBS_CHK && nxt == ST_PRBS_CHK) ? prbs_tot + 1'b1 : '0;
      if (nxt == ST_OFF || (nxt == ST_LINK_UP && st != ST_LINK_UP)) retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_cnt + 1'b1;
      // outputs decode the next state so they line up with the state register
      pll_en      <= nxt inside {ST_PLL_WAIT, ST_CDR_WAIT, ST_PRBS_CHK, ST_LINK_UP};
      cdr_en      <= nxt inside {ST_CDR_WAIT, ST_PRBS_CHK, ST_LINK_UP};
      tx_en       <= nxt inside {ST_CDR_WAIT, ST_PRBS_CHK, ST_LINK_UP};
      rx_en       <= nxt inside {ST_CDR_WAIT, ST_PRBS_CHK, ST_LINK_UP};
      prbs_chk_en <= (nxt == ST_PRBS_CHK) || (nxt == ST_LINK_UP && test_mode);
      link_up     <= nxt == ST_LINK_UP;
      fault       <= nxt == ST_FAULT;
    end
  end

endmodule

// File: tb/tb_serdesphy_link_ctrl.sv
// Directed bench for serdesphy_link_ctrl with shortened timing parameters.
`timescale 1ns/1ps
module tb_serdesphy_link_ctrl;

  logic       clk_ref_24m = 1'b0;
  logic       rst_n = 1'b1;
  logic       dvdd_ok = 1'b0, avdd_ok = 1'b0, link_en = 1'b0, test_mode = 1'b0;
  logic       pll_lock = 1'b0, cdr_lock = 1'b0, prbs_err = 1'b0;
  logic       pll_en, cdr_en, tx_en, rx_en, prbs_chk_en, link_up, fault;
  logic [2:0] state;
  logic [1:0] retry_cnt;

  logic [11:0] obs, exp_v;
  int checks = 0;
  int errors = 0;

  // {state, retry_cnt, pll_en, cdr_en, tx_en, rx_en, prbs_chk_en, link_up, fault}
  assign obs = {state, retry_cnt, pll_en, cdr_en, tx_en, rx_en, prbs_chk_en, link_up, fault};

  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_PLL  = 7'b1000000;
  localparam logic [6:0] O_CDR  = 7'b1111000;
  localparam logic [6:0] O_PRBS = 7'b1111100;
  localparam logic [6:0] O_UP0  = 7'b1111010;
  localparam logic [6:0] O_UP1  = 7'b1111110;
  localparam logic [6:0] O_FLT  = 7'b0000001;

  always #20 clk_ref_24m = ~clk_ref_24m;

  serdesphy_link_ctrl #(
    .PWR_SETTLE(8), .PLL_TIMEOUT(32), .CDR_TIMEOUT(64), .PRBS_WINDOW(16), .MAX_RETRY(3)
  ) dut (
    .clk_ref_24m(clk_ref_24m), .rst_n(rst_n), .dvdd_ok(dvdd_ok), .avdd_ok(avdd_ok),
    .link_en(link_en), .test_mode(test_mode), .pll_lock(pll_lock), .cdr_lock(cdr_lock),
    .prbs_err(prbs_err), .pll_en(pll_en), .cdr_en(cdr_en), .tx_en(tx_en), .rx_en(rx_en),
    .prbs_chk_en(prbs_chk_en), .link_up(link_up), .fault(fault), .state(state),
    .retry_cnt(retry_cnt)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_ref_24m);
      #1;
    end
  endtask

  task automatic go_off();
    link_en = 1'b0; test_mode = 1'b0; pll_lock = 1'b0; cdr_lock = 1'b0; prbs_err = 1'b0;
    dvdd_ok = 1'b1; avdd_ok = 1'b1;
    tick(3);
  endtask

  task automatic test_reset();
    dvdd_ok = 1'b1; avdd_ok = 1'b1;
    #2 rst_n = 1'b0;
    tick(2);
    exp_v = {3'd0, 2'd0, O_NONE}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_state: got %h exp %h", obs, exp_v); end
    rst_n = 1'b1;
    tick(2);
    exp_v = {3'd0, 2'd0, O_NONE}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL idle_off: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_nominal();
    go_off();
    link_en = 1'b1;
    tick(8);
    exp_v = {3'd1, 2'd0, O_NONE}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL nom_pwr_wait: got %h exp %h", obs, exp_v); end
    tick(1);
    exp_v = {3'd2, 2'd0, O_PLL}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL nom_pll_wait: got %h exp %h", obs, exp_v); end
    tick(11);
    pll_lock = 1'b1;
    tick(2);
    exp_v = {3'd2, 2'd0, O_PLL}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL nom_pll_sync: got %h exp %h", obs, exp_v); end
    tick(1);
    exp_v = {3'd3, 2'd0, O_CDR}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL nom_cdr_wait: got %h exp %h", obs, exp_v); end
    tick(17);
    cdr_lock = 1'b1;
    tick(2);
    exp_v = {3'd3, 2'd0, O_CDR}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL nom_cdr_sync: got %h exp %h", obs, exp_v); end
    tick(1);
    exp_v = {3'd5, 2'd0, O_UP0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL nom_link_up: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_pll_timeout();
    go_off();
    link_en = 1'b1;
    tick(40);
    exp_v = {3'd2, 2'd0, O_PLL}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pll_to_last: got %h exp %h", obs, exp_v); end
    tick(1);
    exp_v = {3'd1, 2'd1, O_NONE}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pll_to_retry1: got %h exp %h", obs, exp_v); end
    tick(79);
    exp_v = {3'd2, 2'd2, O_PLL}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pll_to_third: got %h exp %h", obs, exp_v); end
    tick(1);
    exp_v = {3'd6, 2'd2, O_FLT}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pll_to_fault: got %h exp %h", obs, exp_v); end
    tick(5);
    exp_v = {3'd6, 2'd2, O_FLT}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fault_sticky: got %h exp %h", obs, exp_v); end
    link_en = 1'b0;
    tick(1);
    exp_v = {3'd0, 2'd0, O_NONE}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fault_clear: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_lock_vs_timeout();
    go_off();
    link_en = 1'b1;
    tick(38);
    pll_lock = 1'b1;
    tick(2);
    exp_v = {3'd2, 2'd0, O_PLL}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL lvt_pre: got %h exp %h", obs, exp_v); end
    tick(1);
    exp_v = {3'd3, 2'd0, O_CDR}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL lvt_lock_wins: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_prbs();
    go_off();
    test_mode = 1'b1; pll_lock = 1'b1; cdr_lock = 1'b1; link_en = 1'b1;
    tick(11);
    exp_v = {3'd4, 2'd0, O_PRBS}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL prbs_enter: got %h exp %h", obs, exp_v); end
    tick(4);
    prbs_err = 1'b1;
    tick(1);
    prbs_err = 1'b0;
    tick(15);
    exp_v = {3'd4, 2'd0, O_PRBS}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL prbs_extended: got %h exp %h", obs, exp_v); end
    tick(1);
    exp_v = {3'd5, 2'd0, O_UP1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL prbs_link_up: got %h exp %h", obs, exp_v); end
  endtask

  // runs from the LINK_UP state left by test_prbs
  task automatic test_cdr_drop();
    int waited;
    cdr_lock = 1'b0;
    tick(1);
    cdr_lock = 1'b1;
    tick(1);
    exp_v = {3'd5, 2'd0, O_UP1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL drop_sync_lag: got %h exp %h", obs, exp_v); end
    tick(1);
    exp_v = {3'd1, 2'd1, O_NONE}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL drop_retry: got %h exp %h", obs, exp_v); end
    waited = 0;
    while (!link_up && waited < 60) begin
      tick(1);
      waited++;
    end
    exp_v = {3'd5, 2'd0, O_UP1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL drop_recover: got %h exp %h after %0d cycles", obs, exp_v, waited); end
  endtask

  task automatic test_pwr_drop();
    go_off();
    pll_lock = 1'b1; link_en = 1'b1;
    tick(73);
    exp_v = {3'd3, 2'd0, O_CDR}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL cdr_to_last: got %h exp %h", obs, exp_v); end
    tick(1);
    exp_v = {3'd1, 2'd1, O_NONE}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL cdr_to_retry: got %h exp %h", obs, exp_v); end
    tick(9);
    exp_v = {3'd3, 2'd1, O_CDR}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL cdr_reenter: got %h exp %h", obs, exp_v); end
    tick(2);
    avdd_ok = 1'b0;
    tick(1);
    exp_v = {3'd1, 2'd1, O_NONE}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pwr_drop: got %h exp %h", obs, exp_v); end
    tick(5);
    avdd_ok = 1'b1;
    tick(7);
    exp_v = {3'd1, 2'd1, O_NONE}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pwr_resettle: got %h exp %h", obs, exp_v); end
    tick(1);
    exp_v = {3'd2, 2'd1, O_PLL}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pwr_to_pll: got %h exp %h", obs, exp_v); end
    link_en = 1'b0; avdd_ok = 1'b0;
    tick(1);
    exp_v = {3'd0, 2'd0, O_NONE}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL en_over_pwr: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_async_reset();
    go_off();
    link_en = 1'b1;
    tick(12);
    exp_v = {3'd2, 2'd0, O_PLL}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ar_pll_wait: got %h exp %h", obs, exp_v); end
    #5 rst_n = 1'b0;
    #1;
    exp_v = {3'd0, 2'd0, O_NONE}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ar_immediate: got %h exp %h", obs, exp_v); end
    tick(2);
    rst_n = 1'b1;
    #1;
    exp_v = {3'd0, 2'd0, O_NONE}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ar_release: got %h exp %h", obs, exp_v); end
    tick(1);
    exp_v = {3'd1, 2'd0, O_NONE}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ar_restart: got %h exp %h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_pll_timeout();
    test_lock_vs_timeout();
    test_prbs();
    test_cdr_drop();
    test_pwr_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
